c432_irq_servicer: RTL and testbench

Sequential responder for the c432 27-channel interrupt priority core. It holds pending interrupt requests on buses A/B/C and drives a frozen snapshot onto the core's A/B/C/E inputs. It samples PA/PB/PC/Chan after a programmable settle window and issues a valid/ready acknowledge for the granted channel. On acknowledge handshake it clears the serviced pending bit, and it sits between interrupt sources and the timing-annotated c432 core.

---
 rtl/c432_irq_servicer_if.sv | 38 +++
 rtl/c432_irq_servicer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_c432_irq_servicer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c432_irq_servicer_if.sv
// Request and acknowledge handshakes between interrupt sources/consumer and the c432 servicer.
interface c432_irq_servicer_if;
    // Request channel: a source posts (bus, channel) with a valid/ready handshake.
    logic       req_valid;
    logic [1:0] req_bus;
    logic [3:0] req_chan;
    logic       req_ready;

    // Acknowledge channel: the servicer reports the granted (bus, channel).
    logic       ack_valid;
    logic [1:0] ack_bus;
    logic [3:0] ack_chan;
    logic       ack_ready;

    // Sources and the acknowledge consumer.
    modport master (
        output req_valid,
        output req_bus,
        output req_chan,
        input  req_ready,
        input  ack_valid,
        input  ack_bus,
        input  ack_chan,
        output ack_ready
    );

    // The servicer.
    modport slave (
        input  req_valid,
        input  req_bus,
        input  req_chan,
        output req_ready,
        output ack_valid,
        output ack_bus,
        output ack_chan,
        input  ack_ready
    );
endinterface

// File: rtl/c432_irq_servicer.sv
// Holds pending interrupt requests for buses A/B/C, presents a frozen snapshot to
// the c432 priority core, samples its grant after a settle window and acknowledges
// the granted channel, clearing its pending bit on the acknowledge handshake.
module c432_irq_servicer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    c432_irq_servicer_if.slave  bus_if,
    input  logic [8:0]          i_en_mask,
    output logic [8:0]          o_a_q,
    output logic [8:0]          o_b_q,
    output logic [8:0]          o_c_q,
    output logic [8:0]          o_e_q,
    input  logic                i_pa,
    input  logic                i_pb,
    input  logic                i_pc,
    input  logic [3:0]          i_chan,
    output logic                o_err
);

    localparam int unsigned CH_N    = 9;
    localparam int unsigned BUS_W   = 2;
    localparam int unsigned CHAN_W  = 4;
    localparam logic [BUS_W-1:0]  BUS_A    = BUS_W'(0);
    localparam logic [BUS_W-1:0]  BUS_B    = BUS_W'(1);
    localparam logic [BUS_W-1:0]  BUS_C    = BUS_W'(2);
    localparam logic [BUS_W-1:0]  BUS_BAD  = BUS_W'(3);
    localparam logic [CHAN_W-1:0] CHAN_MAX = CHAN_W'(CH_N - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESENT = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CH_N-1:0]     r_pend_a;
    logic [CH_N-1:0]     r_pend_b;
    logic [CH_N-1:0]     r_pend_c;
    logic [CH_N-1:0]     r_a_q;
    logic [CH_N-1:0]     r_b_q;
    logic [CH_N-1:0]     r_c_q;
    logic [CH_N-1:0]     r_e_q;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ack_valid;
    logic [BUS_W-1:0]    r_ack_bus;
    logic [CHAN_W-1:0]   r_ack_chan;
    logic                r_err;
    logic                r_req_ready;

    // Request decode
    logic                w_req_acc;
    logic                w_req_legal;
    logic                w_req_bad;
    logic [CH_N-1:0]     w_req_oh;
    logic [CH_N-1:0]     w_set_a;
    logic [CH_N-1:0]     w_set_b;
    logic [CH_N-1:0]     w_set_c;

    // Acknowledge decode
    logic                w_ack_hs;
    logic [CH_N-1:0]     w_ack_oh;
    logic [CH_N-1:0]     w_clr_a;
    logic [CH_N-1:0]     w_clr_b;
    logic [CH_N-1:0]     w_clr_c;

    // Grant decode
    logic                w_gnt_any;
    logic [BUS_W-1:0]    w_gnt_bus;
    logic [CH_N-1:0]     w_gnt_snap;
    logic [CH_N-1:0]     w_gnt_oh;
    logic                w_gnt_ok;

    // FSM strobes
    logic                w_pend_en_any;
    logic                w_load_snap;
    logic                w_load_cnt;
    logic                w_cap_ok;
    logic                w_cap_err;

    assign bus_if.req_ready = r_req_ready;
    assign bus_if.ack_valid = r_ack_valid;
    assign bus_if.ack_bus   = r_ack_bus;
    assign bus_if.ack_chan  = r_ack_chan;

    assign o_a_q = r_a_q;
    assign o_b_q = r_b_q;
    assign o_c_q = r_c_q;
    assign o_e_q = r_e_q;
    assign o_err = r_err;

    // Classify incoming requests and build per-bus set masks.
    always_comb begin
        w_req_acc   = bus_if.req_valid & r_req_ready;
        w_req_legal = (bus_if.req_bus != BUS_BAD) && (bus_if.req_chan <= CHAN_MAX);
        w_req_bad   = w_req_acc & ~w_req_legal;
        w_req_oh    = CH_N'(1) << bus_if.req_chan;
        w_set_a     = '0;
        w_set_b     = '0;
        w_set_c     = '0;
        if (w_req_acc && w_req_legal) begin
            case (bus_if.req_bus)
                BUS_A:   w_set_a = w_req_oh;
                BUS_B:   w_set_b = w_req_oh;
                BUS_C:   w_set_c = w_req_oh;
                default: w_set_a = '0;
            endcase
        end
    end

    // Build per-bus clear masks from the acknowledge handshake.
    always_comb begin
        w_ack_hs = r_ack_valid & bus_if.ack_ready;
        w_ack_oh = CH_N'(1) << r_ack_chan;
        w_clr_a  = '0;
        w_clr_b  = '0;
        w_clr_c  = '0;
        if (w_ack_hs) begin
            case (r_ack_bus)
                BUS_A:   w_clr_a = w_ack_oh;
                BUS_B:   w_clr_b = w_ack_oh;
                BUS_C:   w_clr_c = w_ack_oh;
                default: w_clr_a = '0;
            endcase
        end
    end

    // Resolve the core grant (PA > PB > PC) and validate it against the snapshot.
    always_comb begin
        w_gnt_any  = i_pa | i_pb | i_pc;
        w_gnt_bus  = BUS_A;
        w_gnt_snap = r_a_q;
        if (i_pa) begin
            w_gnt_bus  = BUS_A;
            w_gnt_snap = r_a_q;
        end else if (i_pb) begin
            w_gnt_bus  = BUS_B;
            w_gnt_snap = r_b_q;
        end else if (i_pc) begin
            w_gnt_bus  = BUS_C;
            w_gnt_snap = r_c_q;
        end
        w_gnt_oh = CH_N'(1) << i_chan;
        w_gnt_ok = w_gnt_any && (i_chan <= CHAN_MAX) && ((w_gnt_snap & w_gnt_oh) != '0);
    end

    assign w_pend_en_any = ((r_pend_a | r_pend_b | r_pend_c) & i_en_mask) != '0;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load_snap = 1'b0;
        w_load_cnt  = 1'b0;
        w_cap_ok    = 1'b0;
        w_cap_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pend_en_any) begin
                    w_load_snap = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_load_cnt  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_gnt_ok) begin
                    w_cap_ok    = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cap_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                if (w_ack_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pending bits: a set in the same cycle as a clear of that bit wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_a <= '0;
            r_pend_b <= '0;
            r_pend_c <= '0;
        end else begin
            r_pend_a <= (r_pend_a & ~w_clr_a) | w_set_a;
            r_pend_b <= (r_pend_b & ~w_clr_b) | w_set_b;
            r_pend_c <= (r_pend_c & ~w_clr_c) | w_set_c;
        end
    end

    // Snapshot presented to the core; frozen from PRESENT until the next IDLE load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_q <= '0;
            r_b_q <= '0;
            r_c_q <= '0;
            r_e_q <= '0;
        end else if (w_load_snap) begin
            r_a_q <= r_pend_a & i_en_mask;
            r_b_q <= r_pend_b & i_en_mask;
            r_c_q <= r_pend_c & i_en_mask;
            r_e_q <= i_en_mask;
        end
    end

    // Settle counter: loaded in PRESENT, counted down through WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_load_cnt) begin
            r_cnt <= SETTLE_LOAD;
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Acknowledge registers: latched on a good capture, held until the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_valid <= 1'b0;
            r_ack_bus   <= '0;
            r_ack_chan  <= '0;
        end else if (w_cap_ok) begin
            r_ack_valid <= 1'b1;
            r_ack_bus   <= w_gnt_bus;
            r_ack_chan  <= i_chan;
        end else if (w_ack_hs) begin
            r_ack_valid <= 1'b0;
        end
    end

    // Sticky error for illegal requests and unusable grants; request ready after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
        end else begin
            r_err       <= r_err | w_req_bad | w_cap_err;
            r_req_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c432_irq_servicer.sv
// Randomized and directed self-checking bench for c432_irq_servicer with a c432 core stub.
module tb_c432_irq_servicer;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] en_mask;
    logic [8:0] a_q, b_q, c_q, e_q;
    logic       pa, pb, pc;
    logic [3:0] chan;
    logic       err;
    int         stub_mode;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: pending bits per bus/channel and expected sticky error.
    bit mpend [3][9];
    bit mdl_err;

    c432_irq_servicer_if bif ();

    c432_irq_servicer #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus_if    (bif),
        .i_en_mask (en_mask),
        .o_a_q     (a_q),
        .o_b_q     (b_q),
        .o_c_q     (c_q),
        .o_e_q     (e_q),
        .i_pa      (pa),
        .i_pb      (pb),
        .i_pc      (pc),
        .i_chan    (chan),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    // Core stub: bus flags from enabled snapshot bits, lowest channel of highest bus.
    // Mode 1 suppresses all grants, mode 2 reports an out-of-range channel.
    always_comb begin
        logic [8:0] ga, gb, gc, sel;
        ga   = a_q & e_q;
        gb   = b_q & e_q;
        gc   = c_q & e_q;
        pa   = |ga;
        pb   = |gb;
        pc   = |gc;
        sel  = (|ga) ? ga : ((|gb) ? gb : gc);
        chan = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (sel[i]) chan = 4'(i);
        end
        if (stub_mode == 1) begin
            pa = 1'b0;
            pb = 1'b0;
            pc = 1'b0;
        end else if (stub_mode == 2) begin
            chan = 4'd12;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Highest-priority enabled pending entry: first bus A,B,C, then lowest channel.
    function automatic bit pick(output int b, output int c);
        b = 0;
        c = 0;
        for (int bb = 0; bb < 3; bb++)
            for (int cc = 0; cc < 9; cc++)
                if (mpend[bb][cc] && en_mask[cc]) begin
                    b = bb;
                    c = cc;
                    return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [8:0] exp_snap(input int b);
        logic [8:0] v;
        for (int cc = 0; cc < 9; cc++) v[cc] = mpend[b][cc] & en_mask[cc];
        return v;
    endfunction

    task automatic clear_model();
        for (int bb = 0; bb < 3; bb++)
            for (int cc = 0; cc < 9; cc++) mpend[bb][cc] = 1'b0;
        mdl_err = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_a_q"}, 32'(a_q), 32'h0);
        check_eq({tag, "_b_q"}, 32'(b_q), 32'h0);
        check_eq({tag, "_c_q"}, 32'(c_q), 32'h0);
        check_eq({tag, "_e_q"}, 32'(e_q), 32'h0);
        check_eq({tag, "_ack_valid"}, 32'(bif.ack_valid), 32'h0);
        check_eq({tag, "_ack_bus"}, 32'(bif.ack_bus), 32'h0);
        check_eq({tag, "_ack_chan"}, 32'(bif.ack_chan), 32'h0);
        check_eq({tag, "_err"}, 32'(err), 32'h0);
        check_eq({tag, "_req_ready"}, 32'(bif.req_ready), 32'h0);
    endtask

    // One-cycle reset, check reset values, then one more cycle so req_ready rises.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check_reset_vals(tag);
        step();
        check_eq({tag, "_ready_after"}, 32'(bif.req_ready), 32'h1);
    endtask

    // Single-cycle request; leaves the bench one cycle after the handshake.
    task automatic do_req(input int b, input int c);
        bif.req_valid = 1'b1;
        bif.req_bus   = 2'(b);
        bif.req_chan  = 4'(c);
        if (b <= 2 && c <= 8) mpend[b][c] = 1'b1;
        else mdl_err = 1'b1;
        step();
        bif.req_valid = 1'b0;
    endtask

    // Expect no acknowledge for n cycles.
    task automatic expect_no_ack(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bif.ack_valid) seen = 1'b1;
            step();
        end
        check_eq({tag, "_no_ack"}, 32'(seen), 32'h0);
    endtask

    // Wait for the acknowledge the model predicts, check it and the snapshot, hold it
    // for 'hold' cycles of backpressure, then complete the handshake (optionally with a
    // colliding request for the same bit).
    task automatic service_one(input string tag, input int hold, input bit coll, output int waited);
        bit ok, stable;
        int eb, ec;
        logic [1:0] sbus;
        logic [3:0] schan;
        logic [8:0] sa;
        ok     = 1'b0;
        waited = 0;
        for (int i = 0; i < 60; i++) begin
            if (bif.ack_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            waited++;
        end
        check_eq({tag, "_ack_seen"}, 32'(ok), 32'h1);
        if (!ok) return;
        void'(pick(eb, ec));
        check_eq({tag, "_ack_bus"}, 32'(bif.ack_bus), 32'(eb));
        check_eq({tag, "_ack_chan"}, 32'(bif.ack_chan), 32'(ec));
        check_eq({tag, "_a_q"}, 32'(a_q), 32'(exp_snap(0)));
        check_eq({tag, "_b_q"}, 32'(b_q), 32'(exp_snap(1)));
        check_eq({tag, "_c_q"}, 32'(c_q), 32'(exp_snap(2)));
        check_eq({tag, "_e_q"}, 32'(e_q), 32'(en_mask));
        sbus   = bif.ack_bus;
        schan  = bif.ack_chan;
        sa     = a_q;
        stable = 1'b1;
        bif.ack_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!bif.ack_valid || bif.ack_bus != sbus || bif.ack_chan != schan || a_q != sa)
                stable = 1'b0;
        end
        if (hold > 0) check_eq({tag, "_hold_stable"}, 32'(stable), 32'h1);
        bif.ack_ready = 1'b1;
        if (coll) begin
            bif.req_valid = 1'b1;
            bif.req_bus   = 2'(eb);
            bif.req_chan  = 4'(ec);
        end
        step();
        bif.ack_ready = 1'b0;
        bif.req_valid = 1'b0;
        if (!coll) mpend[eb][ec] = 1'b0;
        check_eq({tag, "_ack_drop"}, 32'(bif.ack_valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w, b, c, nreq;
        rst           = 1'b1;
        en_mask       = 9'h1FF;
        stub_mode     = 0;
        bif.req_valid = 1'b0;
        bif.req_bus   = 2'd0;
        bif.req_chan  = 4'd0;
        bif.ack_ready = 1'b0;
        clear_model();
        step();
        step();
        do_reset("reset");

        // Single request, cycle-exact latency (after do_req we are in cycle 1).
        do_req(0, 5);
        check_eq("single_c1_a_q", 32'(a_q), 32'h0);
        step();
        check_eq("single_c2_a_q", 32'(a_q), 32'h020);
        check_eq("single_c2_e_q", 32'(e_q), 32'h1FF);
        step(); step(); step();
        check_eq("single_c5_valid", 32'(bif.ack_valid), 32'h0);
        step();
        check_eq("single_c6_valid", 32'(bif.ack_valid), 32'h1);
        service_one("single", 0, 1'b0, w);
        expect_no_ack("single_idle", 20);

        // Priority: A2 before C0, second ack no sooner than S+3 after the handshake.
        en_mask = 9'h000;
        do_req(2, 0);
        do_req(0, 2);
        en_mask = 9'h1FF;
        service_one("prio1", 0, 1'b0, w);
        service_one("prio2", 0, 1'b0, w);
        check_eq("prio_gap", 32'(w + 1 >= int'(S) + 3), 32'h1);
        check_eq("prio_err", 32'(err), 32'h0);

        // Masking from a clean reset.
        do_reset("mask_rst");
        en_mask = 9'h1F7;
        do_req(1, 3);
        expect_no_ack("mask", 50);
        check_eq("mask_e_q", 32'(e_q), 32'h0);
        en_mask = 9'h1FF;
        service_one("mask_on", 0, 1'b0, w);

        // Backpressure for 10 cycles.
        do_req(0, 7);
        service_one("bp", 10, 1'b0, w);
        expect_no_ack("bp_after", 15);

        // Core reports no grant: error, pending retained.
        stub_mode = 1;
        do_req(2, 4);
        for (int i = 0; i < 12; i++) step();
        check_eq("nogrant_err", 32'(err), 32'h1);
        stub_mode = 0;
        service_one("nogrant_retry", 0, 1'b0, w);
        check_eq("nogrant_err_sticky", 32'(err), 32'h1);

        // Core reports an out-of-range channel.
        do_reset("badchan_rst");
        stub_mode = 2;
        do_req(1, 1);
        for (int i = 0; i < 12; i++) step();
        check_eq("badchan_err", 32'(err), 32'h1);
        stub_mode = 0;
        service_one("badchan_retry", 0, 1'b0, w);

        // Illegal bus 3 request: error and no pending change.
        do_reset("bus3_rst");
        do_req(3, 1);
        step();
        check_eq("bus3_err", 32'(err), 32'h1);
        expect_no_ack("bus3", 20);

        // Request for the acked bit in the handshake cycle keeps it pending.
        do_reset("coll_rst");
        do_req(0, 1);
        service_one("coll1", 2, 1'b1, w);
        service_one("coll2", 0, 1'b0, w);
        expect_no_ack("coll_done", 20);
        check_eq("coll_err", 32'(err), 32'h0);

        // Reset during WAIT.
        do_req(1, 6);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check_reset_vals("rst_wait");
        expect_no_ack("rst_wait", 30);

        // Reset while ack_valid is high.
        do_req(1, 6);
        for (int i = 0; i < 12 && !bif.ack_valid; i++) step();
        check_eq("rst_ack_pre", 32'(bif.ack_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check_reset_vals("rst_ack");
        expect_no_ack("rst_ack", 30);

        // Randomized rounds: post requests while masked, then service under a random mask.
        do_reset("rand_rst");
        for (int r = 0; r < 12; r++) begin
            en_mask = 9'h000;
            nreq = $urandom_range(1, 6);
            for (int k = 0; k < nreq; k++) begin
                b = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
                c = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                do_req(b, c);
            end
            en_mask = 9'($urandom_range(1, 511));
            while (pick(b, c)) begin
                service_one($sformatf("rand%0d", r), $urandom_range(0, 3), 1'b0, w);
                if (w >= 60) break;
            end
            expect_no_ack($sformatf("rand%0d_end", r), 15);
            check_eq($sformatf("rand%0d_err", r), 32'(err), 32'(mdl_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
